// File: rtl/parity_core_scheduler_if.sv
// ---------------------------------------------------------------------------
// parity_core_scheduler_if
//   Bundles the requester bus, the external XOR-core connection and the
//   parity result handshake of parity_core_scheduler.
//   master : scheduler side (drives gnt, bit_idx, core_in, par_*)
//   slave  : requesters / core / parity consumer side
//   req[N_REQ]      request level per requester
//   bit_in[N_REQ]   serial data bit per requester
//   gnt[N_REQ]      one-hot grant
//   bit_idx[CNT_W]  index of the frame bit consumed this cycle
//   core_in         next-state input to the shared core
//   core_out        current core state
//   par_valid/par_ready/par_out/par_id  parity result handshake
// ---------------------------------------------------------------------------
interface parity_core_scheduler_if #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 8
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] bit_in;
  logic [N_REQ-1:0] gnt;
  logic [CNT_W-1:0] bit_idx;
  logic             core_in;
  logic             core_out;
  logic             par_valid;
  logic             par_ready;
  logic             par_out;
  logic [ID_W-1:0]  par_id;

  modport master (
    input  req, bit_in, core_out, par_ready,
    output gnt, bit_idx, core_in, par_valid, par_out, par_id
  );

  modport slave (
    output req, bit_in, core_out, par_ready,
    input  gnt, bit_idx, core_in, par_valid, par_out, par_id
  );
endinterface

// File: rtl/parity_core_scheduler.sv
// ---------------------------------------------------------------------------
// parity_core_scheduler
//   Round-robin scheduler that time-shares one external 1-bit XOR-accumulator
//   core (st_next = core_in ^ st) among N_REQ requesters. Each grant streams
//   the winner's FRAME_LEN-bit frame through the core, then offers the frame
//   parity on a valid/ready handshake and clears the core on acceptance.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : parity_core_scheduler_if.master (requests, grant, core link,
//            parity handshake)
// ---------------------------------------------------------------------------
module parity_core_scheduler #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  parity_core_scheduler_if.master        bus
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic [ID_W-1:0]  winner_reg;
  logic [ID_W-1:0]  rr_last_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             par_valid_reg;
  logic [ID_W-1:0]  par_id_reg;

  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic [ID_W-1:0]  scan_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             core_in_next;

  // Round-robin search: start one past the last winner and walk N_REQ
  // positions with wrap, taking the first active request.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = rr_last_reg;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = (scan_idx == LAST_ID) ? '0 : scan_idx + 1'b1;
      if (!pick_found && bus.req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign pick_onehot[gi] = (pick_idx == ID_W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      winner_reg    <= '0;
      rr_last_reg   <= LAST_ID;
      cnt_reg       <= '0;
      par_valid_reg <= 1'b0;
      par_id_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            gnt_reg    <= pick_onehot;
            winner_reg <= pick_idx;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          if (cnt_reg == LAST_BIT) begin
            // cnt returns to 0 here so it never exceeds LAST_BIT
            cnt_reg       <= '0;
            par_valid_reg <= 1'b1;
            par_id_reg    <= winner_reg;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (bus.par_ready) begin
            par_valid_reg <= 1'b0;
            par_id_reg    <= '0;
            gnt_reg       <= '0;
            rr_last_reg   <= winner_reg;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          gnt_reg       <= '0;
          cnt_reg       <= '0;
          par_valid_reg <= 1'b0;
          par_id_reg    <= '0;
        end
      endcase
    end
  end

  // Core drive: feeding core_out back (x ^ x = 0) clears the core; driving 0
  // makes it hold its value while the parity waits for acceptance.
  always_comb begin
    core_in_next = 1'b0;
    case (state_reg)
      IDLE:    core_in_next = bus.core_out;
      RUN:     core_in_next = bus.bit_in[winner_reg];
      DONE:    core_in_next = bus.par_ready ? bus.core_out : 1'b0;
      default: core_in_next = 1'b0;
    endcase
  end

  assign bus.core_in   = core_in_next;
  assign bus.gnt       = gnt_reg;
  assign bus.bit_idx   = (state_reg == RUN) ? cnt_reg : '0;
  assign bus.par_valid = par_valid_reg;
  assign bus.par_out   = par_valid_reg & bus.core_out;
  assign bus.par_id    = par_id_reg;
endmodule

// File: tb/tb_parity_core_scheduler.sv
// ---------------------------------------------------------------------------
// tb_parity_core_scheduler
//   Directed bench for parity_core_scheduler: an N_REQ=4/FRAME_LEN=8 instance
//   plus an N_REQ=4/FRAME_LEN=1 instance, each with its own model of the
//   external XOR core and combinational requesters that serve frame bits
//   MSB-first according to gnt/bit_idx.
// ---------------------------------------------------------------------------
module tb_parity_core_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  parity_core_scheduler_if #(.N_REQ(4), .FRAME_LEN(8)) bus ();
  parity_core_scheduler_if #(.N_REQ(4), .FRAME_LEN(1)) bus1 ();

  parity_core_scheduler #(.N_REQ(4), .FRAME_LEN(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  parity_core_scheduler #(.N_REQ(4), .FRAME_LEN(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  // External XOR-accumulator cores, reset by the same rst
  logic core_st;
  logic core_st1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) core_st <= 1'b0;
    else     core_st <= bus.core_in ^ core_st;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) core_st1 <= 1'b0;
    else     core_st1 <= bus1.core_in ^ core_st1;
  end
  assign bus.core_out  = core_st;
  assign bus1.core_out = core_st1;

  // Requesters: frame_bits[g][7] is bit 0 of requester g's frame
  logic [7:0] frame_bits [4];
  logic       bit1;
  always_comb begin
    bus.bit_in = '0;
    for (int g = 0; g < 4; g++) begin
      if (bus.gnt[g]) bus.bit_in[g] = frame_bits[g][3'd7 - bus.bit_idx];
    end
  end
  assign bus1.bit_in = bus1.gnt & {4{bit1}};

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    for (int g = 0; g < 4; g++) frame_bits[g] = 8'h00;
    bit1 = 1'b0;
    rst = 1'b1;
    bus.req = '0;  bus.par_ready = 1'b1;
    bus1.req = '0; bus1.par_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); else passed++;
    total++; if (bus.par_valid !== 1'b0) $display("FAIL reset_par_valid: got %b expected 0", bus.par_valid); else passed++;
    total++; if (bus.bit_idx !== 3'd0) $display("FAIL reset_bit_idx: got %0d expected 0", bus.bit_idx); else passed++;
    total++; if (bus.par_id !== 2'd0) $display("FAIL reset_par_id: got %0d expected 0", bus.par_id); else passed++;
    total++; if (bus.par_out !== 1'b0) $display("FAIL reset_par_out: got %b expected 0", bus.par_out); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.gnt !== 4'b0000) $display("FAIL idle_no_req_gnt: got %b expected 0000", bus.gnt); else passed++;
    total++; if (bus1.gnt !== 4'b0000) $display("FAIL idle_no_req_gnt_fl1: got %b expected 0000", bus1.gnt); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    int gnt_cycles;
    int lat;
    logic pv_out;
    logic [1:0] pv_id;
    logic [2:0] idx3;
    logic [2:0] idx8;
    gnt_cycles = 0; lat = 0; pv_out = 1'bx; pv_id = 2'bxx; idx3 = 3'bxxx; idx8 = 3'bxxx;
    frame_bits[0] = 8'b1011_0011;
    bus.par_ready = 1'b1;
    bus.req = 4'b0001;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) bus.req = 4'b0000;
      if (bus.gnt == 4'b0001) gnt_cycles++;
      if (c == 3) idx3 = bus.bit_idx;
      if (c == 8) idx8 = bus.bit_idx;
      if (bus.par_valid && lat == 0) begin
        lat = c; pv_out = bus.par_out; pv_id = bus.par_id;
      end
    end
    total++; if (gnt_cycles != 9) $display("FAIL single_gnt_cycles: got %0d expected 9", gnt_cycles); else passed++;
    total++; if (lat != 9) $display("FAIL single_latency: got %0d expected 9", lat); else passed++;
    total++; if (pv_out !== 1'b1) $display("FAIL single_par_out: got %b expected 1", pv_out); else passed++;
    total++; if (pv_id !== 2'd0) $display("FAIL single_par_id: got %0d expected 0", pv_id); else passed++;
    total++; if (idx3 !== 3'd2) $display("FAIL single_bit_idx_c3: got %0d expected 2", idx3); else passed++;
    total++; if (idx8 !== 3'd7) $display("FAIL single_bit_idx_last: got %0d expected 7", idx8); else passed++;
    total++; if (bus.gnt !== 4'b0000) $display("FAIL single_gnt_after: got %b expected 0000", bus.gnt); else passed++;
    total++; if (bus.par_valid !== 1'b0) $display("FAIL single_valid_after: got %b expected 0", bus.par_valid); else passed++;
    $display("test_single_frame done: par_out=%b par_id=%0d latency=%0d", pv_out, pv_id, lat);
  endtask

  task automatic test_round_robin();
    logic [1:0] ids  [5];
    logic       outs [5];
    logic [3:0] gnts [5];
    int         gaps [5];
    logic [1:0] exp_id  [5];
    logic       exp_out [5];
    int nv;
    int gap;
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_out = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin ids[i] = 2'bxx; outs[i] = 1'bx; gnts[i] = 4'bxxxx; gaps[i] = -1; end
    frame_bits[0] = 8'h01; frame_bits[1] = 8'h03;
    frame_bits[2] = 8'h07; frame_bits[3] = 8'hFF;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.par_ready = 1'b1;
    bus.req = 4'b1111;
    nv = 0; gap = 0;
    for (int c = 0; c < 80 && nv < 5; c++) begin
      @(negedge clk);
      if (bus.gnt == 4'b0000) gap++;
      if (bus.par_valid) begin
        ids[nv] = bus.par_id; outs[nv] = bus.par_out; gnts[nv] = bus.gnt; gaps[nv] = gap;
        gap = 0;
        nv++;
        if (nv == 5) bus.req = 4'b0000;
      end
    end
    total++; if (nv != 5) $display("FAIL rr_frames: got %0d expected 5", nv); else passed++;
    for (int i = 0; i < 5; i++) begin
      $display("rr frame %0d: par_id=%0d par_out=%b gnt=%b gap=%0d", i, ids[i], outs[i], gnts[i], gaps[i]);
      total++; if (ids[i] !== exp_id[i]) $display("FAIL rr_id_%0d: got %0d expected %0d", i, ids[i], exp_id[i]); else passed++;
      total++; if (outs[i] !== exp_out[i]) $display("FAIL rr_out_%0d: got %b expected %b", i, outs[i], exp_out[i]); else passed++;
      total++; if (gnts[i] !== (4'b0001 << exp_id[i])) $display("FAIL rr_gnt_%0d: got %b expected %b", i, gnts[i], 4'b0001 << exp_id[i]); else passed++;
      if (i > 0) begin
        total++; if (gaps[i] != 1) $display("FAIL rr_gap_%0d: got %0d expected 1", i, gaps[i]); else passed++;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit seen;
    frame_bits[3] = 8'b0000_0001;
    bus.par_ready = 1'b0;
    bus.req = 4'b1000;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.par_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) $display("FAIL bp_valid_seen: got %b expected 1", seen); else passed++;
    for (int h = 0; h < 5; h++) begin
      $display("bp hold %0d: par_valid=%b par_out=%b par_id=%0d", h, bus.par_valid, bus.par_out, bus.par_id);
      total++; if (bus.par_out !== 1'b1) $display("FAIL bp_hold_out_%0d: got %b expected 1", h, bus.par_out); else passed++;
      total++; if (bus.par_id !== 2'd3) $display("FAIL bp_hold_id_%0d: got %0d expected 3", h, bus.par_id); else passed++;
      total++; if (bus.gnt !== 4'b1000) $display("FAIL bp_hold_gnt_%0d: got %b expected 1000", h, bus.gnt); else passed++;
      @(negedge clk);
    end
    total++; if (bus.par_valid !== 1'b1) $display("FAIL bp_still_valid: got %b expected 1", bus.par_valid); else passed++;
    frame_bits[3] = 8'h00;
    bus.par_ready = 1'b1;
    @(negedge clk);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.par_valid) seen = 1'b1;
    end
    $display("bp next frame: par_valid=%b par_out=%b par_id=%0d", bus.par_valid, bus.par_out, bus.par_id);
    total++; if (seen !== 1'b1) $display("FAIL bp_next_seen: got %b expected 1", seen); else passed++;
    total++; if (bus.par_out !== 1'b0) $display("FAIL bp_no_carry: got %b expected 0", bus.par_out); else passed++;
    total++; if (bus.par_id !== 2'd3) $display("FAIL bp_next_id: got %0d expected 3", bus.par_id); else passed++;
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit got;
    frame_bits[0] = 8'hFF;
    bus.par_ready = 1'b1;
    bus.req = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0000 && bus.bit_idx == 3'd3) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) $display("FAIL rm_reached_bit3: got %b expected 1", seen); else passed++;
    rst = 1'b1;
    bus.req = 4'b0000;
    @(negedge clk);
    total++; if (bus.gnt !== 4'b0000) $display("FAIL rm_gnt: got %b expected 0000", bus.gnt); else passed++;
    total++; if (bus.par_valid !== 1'b0) $display("FAIL rm_par_valid: got %b expected 0", bus.par_valid); else passed++;
    total++; if (bus.bit_idx !== 3'd0) $display("FAIL rm_bit_idx: got %0d expected 0", bus.bit_idx); else passed++;
    rst = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.par_valid) got = 1'b1;
    end
    total++; if (got !== 1'b0) $display("FAIL rm_no_valid: got %b expected 0", got); else passed++;
    frame_bits[2] = 8'b1000_0000;
    bus.req = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.par_valid) seen = 1'b1;
    end
    $display("rm frame: par_valid=%b par_out=%b par_id=%0d", bus.par_valid, bus.par_out, bus.par_id);
    total++; if (seen !== 1'b1) $display("FAIL rm_frame_seen: got %b expected 1", seen); else passed++;
    total++; if (bus.par_out !== 1'b1) $display("FAIL rm_par_out: got %b expected 1", bus.par_out); else passed++;
    total++; if (bus.par_id !== 2'd2) $display("FAIL rm_par_id: got %0d expected 2", bus.par_id); else passed++;
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_req_drop();
    int run;
    bit seen;
    logic pv_out;
    logic [1:0] pv_id;
    frame_bits[1] = 8'b0110_0001;
    bus.par_ready = 1'b1;
    bus.req = 4'b0010;
    run = 0; seen = 1'b0; pv_out = 1'bx; pv_id = 2'bxx;
    for (int c = 0; c < 25 && !seen; c++) begin
      @(negedge clk);
      if (bus.gnt == 4'b0010 && !bus.par_valid) begin
        run++;
        if (bus.bit_idx == 3'd2) bus.req = 4'b0000;
      end
      if (bus.par_valid) begin
        seen = 1'b1; pv_out = bus.par_out; pv_id = bus.par_id;
      end
    end
    $display("req drop: run=%0d par_out=%b par_id=%0d", run, pv_out, pv_id);
    total++; if (seen !== 1'b1) $display("FAIL drop_valid_seen: got %b expected 1", seen); else passed++;
    total++; if (run != 8) $display("FAIL drop_run_cycles: got %0d expected 8", run); else passed++;
    total++; if (pv_out !== 1'b1) $display("FAIL drop_par_out: got %b expected 1", pv_out); else passed++;
    total++; if (pv_id !== 2'd1) $display("FAIL drop_par_id: got %0d expected 1", pv_id); else passed++;
    @(negedge clk);
    total++; if (bus.gnt !== 4'b0000) $display("FAIL drop_gnt_after: got %b expected 0000", bus.gnt); else passed++;
  endtask

  task automatic test_frame_len1();
    int run;
    bit seen;
    logic pv_out;
    logic [1:0] pv_id;
    logic idx;
    // frame of bit 1 from requester 0
    bit1 = 1'b1;
    bus1.par_ready = 1'b1;
    bus1.req = 4'b0001;
    run = 0; seen = 1'b0; pv_out = 1'bx; pv_id = 2'bxx; idx = 1'bx;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus1.gnt == 4'b0001 && !bus1.par_valid) begin
        run++; idx = bus1.bit_idx; bus1.req = 4'b0000;
      end
      if (bus1.par_valid) begin
        seen = 1'b1; pv_out = bus1.par_out; pv_id = bus1.par_id;
      end
    end
    $display("fl1 frame A: run=%0d par_out=%b par_id=%0d", run, pv_out, pv_id);
    total++; if (run != 1) $display("FAIL fl1_run_cycles: got %0d expected 1", run); else passed++;
    total++; if (pv_out !== 1'b1) $display("FAIL fl1_par_out: got %b expected 1", pv_out); else passed++;
    total++; if (pv_id !== 2'd0) $display("FAIL fl1_par_id: got %0d expected 0", pv_id); else passed++;
    total++; if (idx !== 1'b0) $display("FAIL fl1_bit_idx: got %b expected 0", idx); else passed++;
    // frame of bit 0 from requester 2
    @(negedge clk);
    bit1 = 1'b0;
    bus1.req = 4'b0100;
    seen = 1'b0; pv_out = 1'bx; pv_id = 2'bxx;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus1.gnt != 4'b0000) bus1.req = 4'b0000;
      if (bus1.par_valid) begin
        seen = 1'b1; pv_out = bus1.par_out; pv_id = bus1.par_id;
      end
    end
    $display("fl1 frame B: par_out=%b par_id=%0d", pv_out, pv_id);
    total++; if (pv_out !== 1'b0) $display("FAIL fl1b_par_out: got %b expected 0", pv_out); else passed++;
    total++; if (pv_id !== 2'd2) $display("FAIL fl1b_par_id: got %0d expected 2", pv_id); else passed++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_req_drop();
    test_frame_len1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
